hockey_display: RTL and testbench

HOCKEY_DISPLAY -- requirements
Module: hockey_display

---
 rtl/hockey_display_pkg.sv | 27 ++
 rtl/hockey_display_ssd_decoder.sv | 28 ++
 rtl/hockey_display.sv | 168 ++++++++++++++++
 tb/tb_hockey_display.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hockey_display_pkg.sv
// Shared encodings for the hockey game: FSM state codes and seven-segment glyph codes.
// Used by both the game FSM and the display driver.
package hockey_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_DISPLAY   = 4'd1;
    localparam logic [3:0] ST_HIT_A     = 4'd2;
    localparam logic [3:0] ST_HIT_B     = 4'd3;
    localparam logic [3:0] ST_SEND_A    = 4'd4;
    localparam logic [3:0] ST_SEND_B    = 4'd5;
    localparam logic [3:0] ST_RESP_A    = 4'd6;
    localparam logic [3:0] ST_RESP_B    = 4'd7;
    localparam logic [3:0] ST_GOAL_A    = 4'd8;
    localparam logic [3:0] ST_GOAL_B    = 4'd9;
    localparam logic [3:0] ST_GAME_OVER = 4'd10;

    // Glyph codes 0-9 are the decimal digits themselves
    localparam logic [3:0] GLYPH_A     = 4'd10;
    localparam logic [3:0] GLYPH_B     = 4'd11;
    localparam logic [3:0] GLYPH_DASH  = 4'd12;
    localparam logic [3:0] GLYPH_BLANK = 4'd15;

    function automatic logic [3:0] coord_glyph(input logic [2:0] v);
        return (v <= 3'd4) ? {1'b0, v} : GLYPH_DASH;
    endfunction

endpackage

// File: rtl/hockey_display_ssd_decoder.sv
// Combinational glyph-code to seven-segment decoder; segments gfedcba, active-low.
module ssd_decoder
    import hockey_pkg::*;
(
    input  logic [3:0] glyph,
    output logic [6:0] seg
);

    always_comb begin
        case (glyph)
            4'd0:       seg = 7'b1000000;
            4'd1:       seg = 7'b1111001;
            4'd2:       seg = 7'b0100100;
            4'd3:       seg = 7'b0110000;
            4'd4:       seg = 7'b0011001;
            4'd5:       seg = 7'b0010010;
            4'd6:       seg = 7'b0000010;
            4'd7:       seg = 7'b1111000;
            4'd8:       seg = 7'b0000000;
            4'd9:       seg = 7'b0010000;
            GLYPH_A:    seg = 7'b0001000;
            GLYPH_B:    seg = 7'b0000011;
            GLYPH_DASH: seg = 7'b0111111;
            default:    seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/hockey_display.sv
// Hockey game display driver: multiplexed 8-digit seven-segment scan, puck column
// lamps and player lamps, all derived from a registered copy of the game state.
module hockey_display
    import hockey_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 4,
    parameter int unsigned BLINK_DIV = 16
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Current_State,
    input  logic [2:0] X_COORD,
    input  logic [2:0] Y_COORD,
    input  logic [1:0] A_Score,
    input  logic [1:0] B_Score,
    input  logic       flag,
    output logic       LEDA,
    output logic       LEDB,
    output logic [4:0] LEDX,
    output logic [7:0] AN,
    output logic [6:0] SEG
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [3:0]         cs_q;
    logic [2:0]         x_q, y_q;
    logic [1:0]         a_q, b_q;
    logic               flag_q;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [2:0]         digit_idx;
    logic               armed;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_vis;
    logic [3:0]         disp_glyph, glyph;
    logic [6:0]         seg_d;
    logic               led_a_d, led_b_d;
    logic [4:0]         led_x_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q   <= '0;
            x_q    <= '0;
            y_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            flag_q <= 1'b0;
        end else begin
            cs_q   <= Current_State;
            x_q    <= X_COORD;
            y_q    <= Y_COORD;
            a_q    <= A_Score;
            b_q    <= B_Score;
            flag_q <= flag;
        end
    end

    // The first scan period after reset only arms the scan, so digit0 is the first digit lit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            armed     <= 1'b0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            armed    <= 1'b1;
            if (armed)
                digit_idx <= digit_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Clearing on the incoming state keeps a fresh state visible from its first displayed cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (Current_State != cs_q) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_vis <= ~blink_vis;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        case (digit_idx)
            3'd2:    disp_glyph = {2'b00, a_q};
            3'd1:    disp_glyph = GLYPH_DASH;
            3'd0:    disp_glyph = {2'b00, b_q};
            default: disp_glyph = GLYPH_BLANK;
        endcase
    end

    always_comb begin
        glyph   = GLYPH_BLANK;
        led_a_d = 1'b0;
        led_b_d = 1'b0;
        led_x_d = '0;
        if (flag_q || cs_q == ST_GAME_OVER) begin
            if (digit_idx == 3'd3)
                glyph = (a_q == 2'd3) ? GLYPH_A : GLYPH_B;
            else
                glyph = disp_glyph;
            led_x_d = blink_vis ? '1 : '0;
        end else begin
            case (cs_q)
                ST_IDLE: begin
                    case (digit_idx)
                        3'd3:       glyph = GLYPH_A;
                        3'd2, 3'd1: glyph = GLYPH_DASH;
                        3'd0:       glyph = GLYPH_B;
                        default:    glyph = GLYPH_BLANK;
                    endcase
                end
                ST_DISPLAY: glyph = disp_glyph;
                ST_HIT_A, ST_HIT_B, ST_SEND_A, ST_SEND_B, ST_RESP_A, ST_RESP_B: begin
                    if (digit_idx == 3'd0)
                        glyph = coord_glyph(y_q);
                    if (x_q <= 3'd4)
                        led_x_d = 5'b00001 << x_q;
                    led_a_d = (cs_q == ST_HIT_A) || (cs_q == ST_RESP_A);
                    led_b_d = (cs_q == ST_HIT_B) || (cs_q == ST_RESP_B);
                end
                ST_GOAL_A, ST_GOAL_B: begin
                    if (blink_vis)
                        glyph = disp_glyph;
                    led_a_d = (cs_q == ST_GOAL_A);
                    led_b_d = (cs_q == ST_GOAL_B);
                end
                default: glyph = GLYPH_BLANK;
            endcase
        end
    end

    ssd_decoder u_dec (
        .glyph (glyph),
        .seg   (seg_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AN   <= '1;
            SEG  <= '1;
            LEDA <= 1'b0;
            LEDB <= 1'b0;
            LEDX <= '0;
        end else begin
            if (armed) begin
                AN  <= ~(8'b0000_0001 << digit_idx);
                SEG <= seg_d;
            end else begin
                AN  <= '1;
                SEG <= '1;
            end
            LEDA <= led_a_d;
            LEDB <= led_b_d;
            LEDX <= led_x_d;
        end
    end

endmodule

// File: tb/tb_hockey_display.sv
// Scoreboard bench for hockey_display: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_hockey_display;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] SA = 7'h08, SB = 7'h03, SD = 7'h3F, SX = 7'h7F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] Current_State = '0;
    logic [2:0] X_COORD = '0, Y_COORD = '0;
    logic [1:0] A_Score = '0, B_Score = '0;
    logic       flag = 1'b0;
    logic       LEDA, LEDB;
    logic [4:0] LEDX;
    logic [7:0] AN;
    logic [6:0] SEG;

    hockey_display #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .Current_State (Current_State),
        .X_COORD       (X_COORD),
        .Y_COORD       (Y_COORD),
        .A_Score       (A_Score),
        .B_Score       (B_Score),
        .flag          (flag),
        .LEDA          (LEDA),
        .LEDB          (LEDB),
        .LEDX          (LEDX),
        .AN            (AN),
        .SEG           (SEG)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [7:0] an;
        logic [6:0] seg;
        logic       la;
        logic       lb;
        logic [4:0] lx;
        string      tag;
    } exp_t;

    exp_t       q[$];
    logic [6:0] g [8];
    int         k = 0;
    int         checks = 0;
    int         errors = 0;
    logic       done = 1'b0;
    exp_t       cur;

    // k = rising edges since the last reset release
    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    function automatic int dig(input int kk);
        return ((kk - 5) / 4) % 8;
    endfunction

    task automatic push_one(input int kk, input logic [7:0] an, input logic [6:0] seg,
                            input logic la, input logic lb, input logic [4:0] lx, input string tag);
        exp_t e;
        e.k = kk; e.an = an; e.seg = seg; e.la = la; e.lb = lb; e.lx = lx; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic push_range(input int kf, input int kt, input logic la, input logic lb,
                              input logic [4:0] lx, input string tag);
        logic [7:0] one;
        one = 8'h01;
        for (int kk = kf; kk <= kt; kk++)
            push_one(kk, ~(one << dig(kk)), g[dig(kk)], la, lb, lx, tag);
    endtask

    task automatic set_g(input logic [6:0] g7, g6, g5, g4, g3, g2, g1, g0);
        g[7] = g7; g[6] = g6; g[5] = g5; g[4] = g4;
        g[3] = g3; g[2] = g2; g[1] = g1; g[0] = g0;
    endtask

    task automatic set_in(input logic [3:0] st, input logic [2:0] x, input logic [2:0] y,
                          input logic [1:0] a, input logic [1:0] b, input logic f);
        Current_State = st; X_COORD = x; Y_COORD = y; A_Score = a; B_Score = b; flag = f;
    endtask

    task automatic at_k(input int n);
        do begin
            @(posedge clk);
            #1;
        end while (k < n);
    endtask

    task automatic compare(input exp_t e);
        checks++;
        if ({AN, SEG, LEDA, LEDB, LEDX} !== {e.an, e.seg, e.la, e.lb, e.lx}) begin
            errors++;
            $display("FAIL %s k=%0d got AN=%h SEG=%h LEDA=%b LEDB=%b LEDX=%b want AN=%h SEG=%h LEDA=%b LEDB=%b LEDX=%b",
                     e.tag, e.k, AN, SEG, LEDA, LEDB, LEDX, e.an, e.seg, e.la, e.lb, e.lx);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (q.size() > 0 && q[0].k == -1) begin
                cur = q.pop_front();
                compare(cur);
            end
        end else begin
            while (q.size() > 0 && q[0].k < k) begin
                checks++;
                errors++;
                $display("FAIL %s k=%0d got no sample want a compare", q[0].tag, q[0].k);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].k == k) begin
                cur = q.pop_front();
                compare(cur);
            end
        end
        if (done) begin
            if (q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL leftover got %0d pending want 0", q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        push_one(-1, 8'hFF, 7'h7F, 1'b0, 1'b0, 5'b0, "reset_hold");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        push_one(0, 8'hFF, 7'h7F, 1'b0, 1'b0, 5'b0, "release");
        push_one(3, 8'hFF, 7'h7F, 1'b0, 1'b0, 5'b0, "settle");
        set_g(SX, SX, SX, SX, SA, SD, SD, SB);
        push_range(5, 38, 1'b0, 1'b0, 5'b0, "idle");

        at_k(40);
        set_in(4'd1, 3'd0, 3'd0, 2'd2, 2'd1, 1'b0);
        push_range(41, 41, 1'b0, 1'b0, 5'b0, "latency_old");
        set_g(SX, SX, SX, SX, SX, S2, SD, S1);
        push_range(42, 75, 1'b0, 1'b0, 5'b0, "display");

        at_k(80);
        set_in(4'd4, 3'd3, 3'd2, 2'd2, 2'd1, 1'b0);
        set_g(SX, SX, SX, SX, SX, SX, SX, S2);
        push_range(82, 97, 1'b0, 1'b0, 5'b01000, "send_a");

        at_k(100);
        set_in(4'd6, 3'd3, 3'd2, 2'd2, 2'd1, 1'b0);
        push_range(102, 117, 1'b1, 1'b0, 5'b01000, "resp_a");

        at_k(130);
        set_in(4'd8, 3'd0, 3'd0, 2'd1, 2'd0, 1'b0);
        set_g(SX, SX, SX, SX, SX, S1, SD, S0);
        push_range(132, 147, 1'b1, 1'b0, 5'b0, "goal_vis");
        set_g(SX, SX, SX, SX, SX, SX, SX, SX);
        push_range(148, 163, 1'b1, 1'b0, 5'b0, "goal_blank");
        set_g(SX, SX, SX, SX, SX, S1, SD, S0);
        push_range(164, 179, 1'b1, 1'b0, 5'b0, "goal_vis2");

        at_k(190);
        set_in(4'd10, 3'd0, 3'd0, 2'd3, 2'd1, 1'b0);
        set_g(SX, SX, SX, SX, SA, S3, SD, S1);
        push_range(192, 207, 1'b0, 1'b0, 5'b11111, "over_on");
        push_range(208, 223, 1'b0, 1'b0, 5'b00000, "over_off");
        push_range(224, 239, 1'b0, 1'b0, 5'b11111, "over_on2");

        at_k(240);
        set_in(4'd1, 3'd0, 3'd0, 2'd1, 2'd3, 1'b1);
        set_g(SX, SX, SX, SX, SB, S1, SD, S3);
        push_range(242, 257, 1'b0, 1'b0, 5'b11111, "flag_over");

        at_k(270);
        set_in(4'd13, 3'd2, 3'd2, 2'd1, 2'd3, 1'b0);
        set_g(SX, SX, SX, SX, SX, SX, SX, SX);
        push_range(272, 303, 1'b0, 1'b0, 5'b0, "bad_state");

        at_k(310);
        set_in(4'd5, 3'd6, 3'd7, 2'd0, 2'd0, 1'b0);
        set_g(SX, SX, SX, SX, SX, SX, SX, SD);
        push_range(312, 327, 1'b0, 1'b0, 5'b0, "coord_range");

        at_k(330);
        set_in(4'd3, 3'd4, 3'd4, 2'd0, 2'd0, 1'b0);
        set_g(SX, SX, SX, SX, SX, SX, SX, S4);
        push_range(332, 347, 1'b0, 1'b1, 5'b10000, "hit_b_edge");

        at_k(350);
        #1 rst = 1'b1;
        set_in(4'd0, 3'd0, 3'd0, 2'd0, 2'd0, 1'b0);
        push_one(-1, 8'hFF, 7'h7F, 1'b0, 1'b0, 5'b0, "async_reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        set_g(SX, SX, SX, SX, SA, SD, SD, SB);
        push_one(3, 8'hFF, 7'h7F, 1'b0, 1'b0, 5'b0, "resettle");
        push_range(5, 12, 1'b0, 1'b0, 5'b0, "rerelease");

        at_k(14);
        done = 1'b1;
    end

endmodule
